// File: rtl/score_if.sv
// Control and status bundle between the game controller and the score engine.
interface score_if;
    logic        start;
    logic        collide;
    logic [13:0] game_score;
    logic [13:0] high_score;
    logic [1:0]  state;
    logic        milestone;
    logic        new_high;

    // Drives run control and observes the score outputs.
    modport master (
        output start,
        output collide,
        input  game_score,
        input  high_score,
        input  state,
        input  milestone,
        input  new_high
    );

    // The score engine itself.
    modport slave (
        input  start,
        input  collide,
        output game_score,
        output high_score,
        output state,
        output milestone,
        output new_high
    );
endinterface

// File: rtl/score_keeper.sv
// Dino-runner score engine: ticks the score while running, freezes it on
// collision and tracks the best completed run since reset.
module score_keeper #(
    parameter int unsigned TICK_DIV  = 10_000_000,
    parameter int unsigned SCORE_MAX = 9999
) (
    input logic    clk,
    input logic    rst,
    score_if.slave bus
);
    localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);
    localparam logic [13:0] ScoreMax = 14'(SCORE_MAX);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StOver = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [TickW-1:0] tick_q, tick_d;
    logic [6:0]       mod_q, mod_d;
    logic [13:0]      score_q, score_d;
    logic [13:0]      high_q, high_d;
    logic             milestone_q, milestone_d;
    logic             new_high_q, new_high_d;
    logic             tick_wrap;

    assign tick_wrap = (tick_q == TickLast);

    // State register; reset takes effect without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            tick_q      <= '0;
            mod_q       <= '0;
            score_q     <= '0;
            high_q      <= '0;
            milestone_q <= 1'b0;
            new_high_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            mod_q       <= mod_d;
            score_q     <= score_d;
            high_q      <= high_d;
            milestone_q <= milestone_d;
            new_high_q  <= new_high_d;
        end
    end

    // Next-state logic: collision beats a coincident tick, start beats collide
    // outside of RUN.
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        mod_d       = mod_q;
        score_d     = score_q;
        high_d      = high_q;
        milestone_d = 1'b0;
        new_high_d  = new_high_q;

        case (state_q)
            StIdle: begin
                tick_d     = '0;
                mod_d      = '0;
                score_d    = '0;
                new_high_d = 1'b0;
                if (bus.start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (bus.collide) begin
                    state_d = StOver;
                    if (score_q > high_q) begin
                        high_d     = score_q;
                        new_high_d = 1'b1;
                    end
                end else if (tick_wrap) begin
                    tick_d = '0;
                    // At saturation the mod-100 counter stays on 99 so no
                    // further milestone can fire.
                    if (score_q < ScoreMax) begin
                        score_d     = score_q + 14'd1;
                        mod_d       = (mod_q == 7'd99) ? 7'd0 : mod_q + 7'd1;
                        milestone_d = (mod_q == 7'd99);
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            StOver: begin
                if (bus.start) begin
                    state_d    = StRun;
                    tick_d     = '0;
                    mod_d      = '0;
                    score_d    = '0;
                    new_high_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.state      = state_q;
    assign bus.game_score = score_q;
    assign bus.high_score = high_q;
    assign bus.milestone  = milestone_q;
    assign bus.new_high   = new_high_q;
endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: scoreboard of expected per-cycle
// outputs for a TICK_DIV=4 instance, table of short input vectors, and a
// saturation run on a TICK_DIV=1 instance.
module tb_score_keeper;
    localparam logic [1:0] Idle = 2'd0;
    localparam logic [1:0] Run  = 2'd1;
    localparam logic [1:0] Over = 2'd2;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  tag;
        logic [1:0]  st;
        logic [13:0] score;
        logic [13:0] high;
        logic        ms;
        logic        nh;
    } exp_t;

    typedef struct packed {
        logic        rst_before;
        logic        start;
        logic        collide;
        logic [1:0]  st;
        logic [13:0] score;
        logic [13:0] high;
        logic        nh;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [7:0]  phase = 8'd0;
    exp_t        sb[$];

    score_if bus4 ();
    score_if bus1 ();

    score_keeper #(.TICK_DIV(4), .SCORE_MAX(9999)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    score_keeper #(.TICK_DIV(1), .SCORE_MAX(9999)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk4(input string name, input logic [1:0] st, input logic [13:0] score,
                        input logic [13:0] high, input logic ms, input logic nh);
        cmp({name, " state"}, 32'(bus4.state), 32'(st));
        cmp({name, " score"}, 32'(bus4.game_score), 32'(score));
        cmp({name, " high"}, 32'(bus4.high_score), 32'(high));
        cmp({name, " milestone"}, 32'(bus4.milestone), 32'(ms));
        cmp({name, " new_high"}, 32'(bus4.new_high), 32'(nh));
    endtask

    task automatic expect4(input int unsigned c, input logic [1:0] st, input logic [13:0] score,
                           input logic [13:0] high, input logic ms, input logic nh);
        exp_t e;
        e.cyc = c;
        e.tag = phase;
        e.st = st;
        e.score = score;
        e.high = high;
        e.ms = ms;
        e.nh = nh;
        sb.push_back(e);
    endtask

    task automatic check_due();
        exp_t e;
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            chk4($sformatf("phase%0d cyc%0d", e.tag, e.cyc), e.st, e.score, e.high, e.ms, e.nh);
        end
    endtask

    // One clock: inputs are driven and outputs sampled on the falling edge.
    task automatic tick1();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_due();
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk4("async reset", Idle, 14'd0, 14'd0, 1'b0, 1'b0);
        tick1();
        rst = 1'b0;
    endtask

    // Start a run, let it reach target, collide, then watch one idle period.
    task automatic run_collide(input int unsigned target, input logic [13:0] high_in,
                               output logic [13:0] high_out);
        int unsigned n;
        int unsigned t;
        logic        nh;
        logic [13:0] hn;
        n = cyc + 1;
        t = 4 * target;
        nh = (target > high_in);
        hn = nh ? 14'(target) : high_in;
        expect4(n, Run, 14'd0, high_in, 1'b0, 1'b0);
        expect4(n + t, Run, 14'(target), high_in, (target % 100 == 0) && (target != 0), 1'b0);
        expect4(n + t + 1, Over, 14'(target), hn, 1'b0, nh);
        expect4(n + t + 5, Over, 14'(target), hn, 1'b0, nh);
        bus4.start = 1'b1;
        tick1();
        bus4.start = 1'b0;
        repeat (t) tick1();
        bus4.collide = 1'b1;
        tick1();
        bus4.collide = 1'b0;
        repeat (4) tick1();
        high_out = hn;
    endtask

    initial begin
        vec_t        tbl[13];
        int unsigned n;
        logic [13:0] hi;
        int unsigned bad_score;
        int unsigned bad_ms;
        int unsigned ms_cnt;
        logic [13:0] last_ms;
        logic [13:0] exp_sc;
        logic        exp_ms;

        // rst_before, start, collide, state, score, high, new_high
        tbl[0]  = '{1'b0, 1'b1, 1'b1, Run,  14'd0, 14'd51, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, Run,  14'd0, 14'd51, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, Over, 14'd0, 14'd51, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, Over, 14'd0, 14'd51, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, Run,  14'd0, 14'd51, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, Over, 14'd0, 14'd51, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, Idle, 14'd0, 14'd0,  1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, Idle, 14'd0, 14'd0,  1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, Run,  14'd0, 14'd0,  1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, Run,  14'd0, 14'd0,  1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, Run,  14'd0, 14'd0,  1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, Run,  14'd0, 14'd0,  1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, Run,  14'd1, 14'd0,  1'b0};

        rst = 1'b1;
        bus4.start = 1'b0;
        bus4.collide = 1'b0;
        bus1.start = 1'b0;
        bus1.collide = 1'b0;
        repeat (2) tick1();
        chk4("reset", Idle, 14'd0, 14'd0, 1'b0, 1'b0);
        cmp("reset dut1 state", 32'(bus1.state), 32'(Idle));
        cmp("reset dut1 score", 32'(bus1.game_score), 32'd0);
        rst = 1'b0;

        // Reset in the middle of a run, then no restart without start.
        phase = 8'd1;
        n = cyc + 1;
        expect4(n, Run, 14'd0, 14'd0, 1'b0, 1'b0);
        expect4(n + 148, Run, 14'd37, 14'd0, 1'b0, 1'b0);
        bus4.start = 1'b1;
        tick1();
        bus4.start = 1'b0;
        repeat (148) tick1();
        do_reset();
        for (int c = 1; c <= 100; c++) expect4(cyc + c, Idle, 14'd0, 14'd0, 1'b0, 1'b0);
        repeat (100) tick1();

        // Every cycle up to score 205: score = c/4, milestone only at 100, 200.
        do_reset();
        phase = 8'd2;
        n = cyc + 1;
        for (int c = 0; c <= 820; c++) begin
            expect4(n + c, Run, 14'(c / 4), 14'd0,
                    (c > 0) && (c % 4 == 0) && ((c / 4) % 100 == 0), 1'b0);
        end
        expect4(n + 821, Over, 14'd205, 14'd205, 1'b0, 1'b1);
        bus4.start = 1'b1;
        tick1();
        bus4.start = 1'b0;
        repeat (820) tick1();
        bus4.collide = 1'b1;
        tick1();
        bus4.collide = 1'b0;

        // Collide on the very edge where the tick counter wraps.
        do_reset();
        phase = 8'd3;
        n = cyc + 1;
        expect4(n, Run, 14'd0, 14'd0, 1'b0, 1'b0);
        expect4(n + 48, Run, 14'd12, 14'd0, 1'b0, 1'b0);
        expect4(n + 51, Run, 14'd12, 14'd0, 1'b0, 1'b0);
        for (int k = 0; k <= 8; k++) expect4(n + 52 + k, Over, 14'd12, 14'd12, 1'b0, 1'b1);
        bus4.start = 1'b1;
        tick1();
        bus4.start = 1'b0;
        repeat (51) tick1();
        bus4.collide = 1'b1;
        tick1();
        bus4.collide = 1'b0;
        repeat (8) tick1();

        // High score across restarts: 50, then a lower 30, then 51.
        do_reset();
        phase = 8'd4;
        hi = 14'd0;
        run_collide(50, hi, hi);
        run_collide(30, hi, hi);
        run_collide(51, hi, hi);

        // Simultaneous start/collide in each state, start ignored in RUN.
        phase = 8'd5;
        for (int i = 0; i < 13; i++) begin
            if (tbl[i].rst_before) do_reset();
            expect4(cyc + 1, tbl[i].st, tbl[i].score, tbl[i].high, 1'b0, tbl[i].nh);
            bus4.start = tbl[i].start;
            bus4.collide = tbl[i].collide;
            tick1();
        end
        bus4.start = 1'b0;
        bus4.collide = 1'b0;

        // Saturation with a tick every cycle.
        do_reset();
        phase = 8'd6;
        bad_score = 0;
        bad_ms = 0;
        ms_cnt = 0;
        last_ms = 14'd0;
        bus1.start = 1'b1;
        tick1();
        bus1.start = 1'b0;
        for (int c = 0; c <= 10050; c++) begin
            if (c != 0) tick1();
            exp_sc = (c < 9999) ? 14'(c) : 14'd9999;
            exp_ms = (c > 0) && (c <= 9999) && (c % 100 == 0);
            if (bus1.game_score !== exp_sc) bad_score++;
            if (bus1.milestone !== exp_ms) bad_ms++;
            if (bus1.milestone === 1'b1) begin
                ms_cnt++;
                last_ms = bus1.game_score;
            end
        end
        cmp("sat score trace mismatches", bad_score, 32'd0);
        cmp("sat milestone trace mismatches", bad_ms, 32'd0);
        cmp("sat milestone count", ms_cnt, 32'd99);
        cmp("sat last milestone score", 32'(last_ms), 32'd9900);
        cmp("sat final score", 32'(bus1.game_score), 32'd9999);
        cmp("sat state", 32'(bus1.state), 32'(Run));

        cmp("scoreboard drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
